// File: rtl/dmem_dump.sv
// Data-memory dump streamer: freezes the datapath, reads a block of words
// and streams them out over valid/ready while accumulating a checksum.
module dmem_dump #(
  parameter int DW = 32,
  parameter int AW = 6,
  parameter int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [CW-1:0] word_count,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] checksum,
  output logic          dp_hold
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_CAPT = 3'd2;
  localparam logic [2:0] S_SEND = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]    r_state;
  logic [AW-1:0] r_addr;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_data;
  logic [DW-1:0] r_sum;

  logic w_last;
  logic w_hs;

  assign w_last = (r_cnt == CW'(1));
  assign w_hs   = (r_state == S_SEND) && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_sum   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sum <= '0;
            if (word_count != '0) begin
              r_addr  <= base_addr;
              r_cnt   <= word_count;
              r_state <= S_READ;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_READ: r_state <= S_CAPT;
        // Capturing a cycle late covers both comb and registered memories
        S_CAPT: begin
          r_data  <= mem_rdata;
          r_state <= S_SEND;
        end
        S_SEND: begin
          if (w_hs) begin
            r_sum <= r_sum + r_data;
            r_cnt <= r_cnt - CW'(1);
            if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_addr  <= r_addr + AW'(1);
              r_state <= S_READ;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_rd    = (r_state == S_READ) || (r_state == S_CAPT);
  assign mem_addr  = r_addr;
  assign out_data  = r_data;
  assign out_valid = (r_state == S_SEND);
  assign out_last  = (r_state == S_SEND) && w_last;
  assign busy      = mem_rd || out_valid;
  assign dp_hold   = busy;
  assign done      = (r_state == S_DONE);
  assign checksum  = r_sum;

endmodule

// File: tb/tb_dmem_dump.sv
// Bench for dmem_dump: directed table, stall/ghost-start/reset
// sequences and random dumps checked against a memory-array model.
module tb_dmem_dump;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int CW = 7;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] word_count;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;
  logic          dp_hold;

  logic [DW-1:0] mem [DEPTH];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  dmem_dump #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .base_addr(base_addr), .word_count(word_count),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done), .checksum(checksum),
    .dp_hold(dp_hold)
  );

  typedef struct {
    logic [AW-1:0]        base;
    logic [CW-1:0]        cnt;
    bit                   ghost;
    logic [3:0][DW-1:0]   p;
    logic [DW-1:0]        sum;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input int b, input int c, input bit g,
                              input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                              input logic [DW-1:0] w2, input logic [DW-1:0] w3,
                              input logic [DW-1:0] s);
    vec_t v;
    v.base  = AW'(b);
    v.cnt   = CW'(c);
    v.ghost = g;
    v.p[0]  = w0;
    v.p[1]  = w1;
    v.p[2]  = w2;
    v.p[3]  = w3;
    v.sum   = s;
    return v;
  endfunction

  // mode 0: always ready, 1: random backpressure, 2: 5-cycle stall on word 2
  task automatic run_dump(input logic [AW-1:0] base, input logic [CW-1:0] cnt,
                          input int mode, input bit ghost,
                          input logic [DW-1:0] exp_sum, input bit use_exp);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] msum;
    int idx, c, first_v, last_hs, done_c, stall, budget;
    bit rdy, want_valid;
    msum = '0;
    for (int i = 0; i < int'(cnt); i++) begin
      exp_q.push_back(mem[(int'(base) + i) % DEPTH]);
      msum = msum + mem[(int'(base) + i) % DEPTH];
    end
    idx = 0; first_v = -1; last_hs = -1; done_c = -1; stall = 0;
    want_valid = 1'b0;
    budget = 20 * int'(cnt) + 60;
    @(negedge clk);
    start = 1'b1; base_addr = base; word_count = cnt;
    @(posedge clk);
    @(negedge clk);
    c = 1;
    base_addr = AW'($urandom); word_count = CW'($urandom);
    while (done_c < 0 && c <= budget) begin
      start = (ghost && c == 4);
      if (ghost && c == 4) begin
        base_addr = AW'(5); word_count = CW'(9);
      end
      if (done) begin
        done_c = c;
      end else begin
        chk("busy", 32'(busy), 32'd1);
        chk("dp_hold", 32'(dp_hold), 32'd1);
        if (cnt == '0) chk("no_mem_rd", 32'(mem_rd), 32'd0);
        if (want_valid) chk("valid_held", 32'(out_valid), 32'd1);
        want_valid = 1'b0;
        if (out_valid) begin
          if (first_v < 0) first_v = c;
          if (idx >= int'(cnt)) begin
            chk("extra_word", 32'(idx), 32'(cnt));
            rdy = 1'b1;
          end else begin
            chk("out_data", out_data, exp_q[idx]);
            chk("out_last", 32'(out_last), 32'(idx == int'(cnt) - 1));
            chk("mem_addr", 32'(mem_addr), 32'((int'(base) + idx) % DEPTH));
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) rdy = ($urandom_range(0, 99) >= 30);
            else if (idx == 1 && stall < 5) begin
              rdy = 1'b0; stall++;
            end else rdy = 1'b1;
          end
          out_ready = rdy;
          if (rdy) begin
            idx++; last_hs = c;
          end else want_valid = 1'b1;
        end else begin
          out_ready = 1'($urandom_range(0, 1));
        end
      end
      if (done_c < 0) begin
        @(negedge clk);
        c++;
      end
    end
    start = 1'b0;
    chk("done_seen", 32'(done_c > 0), 32'd1);
    chk("word_cnt", 32'(idx), 32'(cnt));
    chk("checksum_model", checksum, msum);
    if (use_exp) chk("checksum_const", checksum, exp_sum);
    if (cnt == '0) begin
      chk("done_c_zero", 32'(done_c), 32'd1);
      chk("no_valid_zero", 32'(first_v), 32'hFFFF_FFFF);
    end else if (done_c > 0) begin
      chk("done_after_hs", 32'(done_c), 32'(last_hs + 1));
      if (mode == 0) begin
        chk("first_valid", 32'(first_v), 32'd3);
        chk("done_cycle", 32'(done_c), 32'(3 * int'(cnt) + 1));
      end
      if (mode == 2) chk("done_stall", 32'(done_c), 32'(3 * int'(cnt) + 6));
    end
    out_ready = 1'b0;
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("sum_hold", checksum, msum);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_out_data"}, out_data, 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_last"}, 32'(out_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_checksum"}, checksum, 32'd0);
    chk({tag, "_dp_hold"}, 32'(dp_hold), 32'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nv;
    logic [AW-1:0] rb;
    logic [CW-1:0] rc;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i * 17 + 3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    vecs[0] = mk(0, 4, 0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd10);
    vecs[1] = mk(62, 4, 0, 32'hA, 32'hB, 32'hC, 32'hD, 32'h2E);
    vecs[2] = mk(10, 0, 0, 32'd9, 32'd9, 32'd9, 32'd9, 32'd0);
    vecs[3] = mk(20, 2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0,
                 32'hFFFF_FFFE);
    vecs[4] = mk(33, 1, 0, 32'h1234_5678, 32'd0, 32'd0, 32'd0, 32'h1234_5678);
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 4; i++)
        mem[(int'(vecs[v].base) + i) % DEPTH] = vecs[v].p[i];
      run_dump(vecs[v].base, vecs[v].cnt, 0, vecs[v].ghost, vecs[v].sum, 1'b1);
    end

    for (int i = 0; i < 4; i++) mem[i] = DW'(i + 1);
    run_dump('0, CW'(4), 2, 1'b0, 32'd10, 1'b1);

    @(negedge clk);
    start = 1'b1; base_addr = '0; word_count = CW'(4); out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    nv = 0;
    for (int c = 0; c < 30 && nv < 2; c++) begin
      if (out_valid) nv++;
      if (nv < 2) @(negedge clk);
    end
    chk("rst_reach_word2", 32'(nv), 32'd2);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_zero("abort");
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_no_valid", 32'(out_valid), 32'd0);
    end
    run_dump('0, CW'(1), 0, 1'b0, 32'd1, 1'b1);

    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      if (t % 5 == 0) mem[0] = 32'hFFFF_FFFF;
      rb = AW'($urandom);
      rc = CW'($urandom_range(0, 70));
      run_dump(rb, rc, 1, t[0], '0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
